// File: rtl/logica_recibir_rtc_hacia_mem_local_if.sv
// Handshake bundle between the field-receive sequencer and its environment.
//   in_inicio_lectura   : one-cycle start pulse
//   in_dato_valido      : RTC controller strobe, in_dato_rtc valid this cycle
//   in_dato_rtc         : byte returned by the RTC controller
//   out_req_lectura     : one-cycle read request for out_addr_mem_local
//   out_addr_mem_local  : field index being read (0 while idle)
//   out_ocupado         : burst in progress
//   out_fin_lectura     : one-cycle pulse when all ten fields are captured
//   out_error           : sticky timeout flag
// master = sequencer side, slave = controller/start side.
interface logica_recibir_rtc_hacia_mem_local_if;
   logic       in_inicio_lectura;
   logic       in_dato_valido;
   logic [7:0] in_dato_rtc;
   logic       out_req_lectura;
   logic [3:0] out_addr_mem_local;
   logic       out_ocupado;
   logic       out_fin_lectura;
   logic       out_error;

   modport master (
      input  in_inicio_lectura, in_dato_valido, in_dato_rtc,
      output out_req_lectura, out_addr_mem_local, out_ocupado, out_fin_lectura, out_error
   );

   modport slave (
      output in_inicio_lectura, in_dato_valido, in_dato_rtc,
      input  out_req_lectura, out_addr_mem_local, out_ocupado, out_fin_lectura, out_error
   );
endinterface

// File: rtl/logica_recibir_rtc_hacia_mem_local.sv
// Reads the ten RTC time/date/timer fields (addresses 0..9) into local holding
// registers. A start pulse launches one burst: per address a read request, a
// wait for the controller's valid strobe, and a capture into that field.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (master)    : start / request / strobe / status handshake
//   out_<field>     : captured field registers (8 bits each), map order
//                     seg_hora, min_hora, hora_hora, dia_fecha, mes_fecha,
//                     jahr_fecha, dia_semana, seg_timer, min_timer, hora_timer
// Optional feature: define LECTURA_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CICLOS cycles and raise the sticky out_error flag.
module logica_recibir_rtc_hacia_mem_local #(
   parameter int unsigned TIMEOUT_CICLOS = 255
) (
   input  logic       clk,
   input  logic       reset,
   logica_recibir_rtc_hacia_mem_local_if.master bus,
   output logic [7:0] out_seg_hora,
   output logic [7:0] out_min_hora,
   output logic [7:0] out_hora_hora,
   output logic [7:0] out_dia_fecha,
   output logic [7:0] out_mes_fecha,
   output logic [7:0] out_jahr_fecha,
   output logic [7:0] out_dia_semana,
   output logic [7:0] out_seg_timer,
   output logic [7:0] out_min_timer,
   output logic [7:0] out_hora_timer
);

   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned NUM_CAMPOS = 10;
   localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(NUM_CAMPOS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} estado_t;

   estado_t             estado, estado_d;
   logic [ADDR_W-1:0]   addr, addr_d;
   logic                captura;
   logic                req, ocupado, fin;
   logic [DATA_W-1:0]   campos [NUM_CAMPOS];

`ifdef LECTURA_TIMEOUT_EN
   localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS - 1);
   logic [7:0] cnt, cnt_d;
   logic       error, error_d;
`endif

   // Next-state, address and capture decode
   always_comb begin
      estado_d = estado;
      addr_d   = addr;
      captura  = 1'b0;
`ifdef LECTURA_TIMEOUT_EN
      cnt_d    = cnt;
      error_d  = error;
`endif
      case (estado)
         IDLE: begin
            if (bus.in_inicio_lectura) begin
               estado_d = REQ;
               addr_d   = '0;
`ifdef LECTURA_TIMEOUT_EN
               error_d  = 1'b0;
`endif
            end
         end
         REQ: begin
            estado_d = WAIT;
`ifdef LECTURA_TIMEOUT_EN
            cnt_d    = '0;
`endif
         end
         WAIT: begin
            if (bus.in_dato_valido) begin
               captura = 1'b1;
               if (addr == ULTIMA) begin
                  estado_d = DONE;
               end else begin
                  addr_d   = addr + ADDR_W'(1);
                  estado_d = REQ;
               end
            end
`ifdef LECTURA_TIMEOUT_EN
            else if (cnt == LIMITE) begin
               estado_d = IDLE;
               addr_d   = '0;
               error_d  = 1'b1;
            end else begin
               cnt_d = cnt + 8'd1;
            end
`endif
         end
         DONE: begin
            estado_d = IDLE;
            addr_d   = '0;
         end
         default: begin
            estado_d = IDLE;
            addr_d   = '0;
         end
      endcase
      // Out-of-map address can only come from a corrupted counter: drop the burst
      if (addr > ULTIMA) begin
         estado_d = IDLE;
         addr_d   = '0;
         captura  = 1'b0;
      end
   end

   // State, address, registered status outputs and field capture
   always_ff @(posedge clk) begin
      if (reset) begin
         estado  <= IDLE;
         addr    <= '0;
         req     <= 1'b0;
         ocupado <= 1'b0;
         fin     <= 1'b0;
         for (int unsigned i = 0; i < NUM_CAMPOS; i++) campos[i] <= '0;
      end else begin
         estado  <= estado_d;
         addr    <= addr_d;
         req     <= (estado_d == REQ);
         ocupado <= (estado_d != IDLE);
         fin     <= (estado_d == DONE);
         for (int unsigned i = 0; i < NUM_CAMPOS; i++)
            if (captura && (addr == ADDR_W'(i))) campos[i] <= bus.in_dato_rtc;
      end
   end

`ifdef LECTURA_TIMEOUT_EN
   // WAIT watchdog and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         error <= 1'b0;
      end else begin
         cnt   <= cnt_d;
         error <= error_d;
      end
   end
   assign bus.out_error = error;
`else
   assign bus.out_error = 1'b0;
`endif

   assign bus.out_req_lectura    = req;
   assign bus.out_addr_mem_local = addr;
   assign bus.out_ocupado        = ocupado;
   assign bus.out_fin_lectura    = fin;

   assign out_seg_hora   = campos[0];
   assign out_min_hora   = campos[1];
   assign out_hora_hora  = campos[2];
   assign out_dia_fecha  = campos[3];
   assign out_mes_fecha  = campos[4];
   assign out_jahr_fecha = campos[5];
   assign out_dia_semana = campos[6];
   assign out_seg_timer  = campos[7];
   assign out_min_timer  = campos[8];
   assign out_hora_timer = campos[9];

endmodule
